sme_feeder: RTL and testbench

- Upstream framing stage for the string-matching engine. Accepts a byte stream over a valid/ready interface, delimited by control codes, and assembles string and pattern records in local buffers.
- Replays the records to the engine as gap-free isstring/ispattern bursts. Bursts are timed against the engine's result strobe, so every burst lands in the exact cycle the engine can accept it.
- Holds the engine in reset whenever no work is staged.

---
 rtl/sme_feeder.sv | 190 +++++++++++++++++++
 tb/tb_sme_feeder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_feeder.sv
// sme_feeder: frames a control-coded byte stream into string/pattern records and replays them
// to the string-matching engine as gap-free bursts. Optional build macro: SME_FEEDER_CASEFOLD_EN.
module sme_feeder #(
   parameter int         SMAX = 32,
   parameter int         PMAX = 8,
   parameter logic [7:0] SOS  = 8'h01,
   parameter logic [7:0] SOP  = 8'h02,
   parameter logic [7:0] EOR  = 8'h04
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       sme_valid,
   output logic       sme_rst,
   output logic       isstring,
   output logic       ispattern,
   output logic [7:0] chardata,
   output logic       busy,
   output logic       err
);

   localparam int            LW   = $clog2(SMAX + 1);
   localparam int            AW   = $clog2(SMAX);
   localparam logic [LW-1:0] ONE  = LW'(1);
   localparam logic [LW-1:0] SCAP = LW'(SMAX);
   localparam logic [LW-1:0] PCAP = LW'(PMAX);

   typedef enum logic [1:0] {HOLD, EMIT_S, EMIT_P, WAIT_RES} state_t;

   function automatic logic [7:0] fold_case(input logic [7:0] b);
`ifdef SME_FEEDER_CASEFOLD_EN
      if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
      else return b;
`else
      return b;
`endif
   endfunction

   state_t        state, state_nx;
   logic [LW-1:0] rd, rd_nx;

   logic [7:0]    asm_buf [SMAX];
   logic [7:0]    str_buf [SMAX];
   logic [LW-1:0] asm_len, slen;
   logic          asm_kind;     // 1 = pattern record
   logic          asm_open, asm_closed;
   logic          new_str, has_str;

   logic          pat_staged, str_staged, start, send_str;
   logic          free_asm, clr_new;
   logic [LW-1:0] cap;

   assign pat_staged = asm_closed && asm_kind;
   assign str_staged = asm_closed && !asm_kind;
   assign in_ready   = !asm_closed;
   assign busy       = (state != HOLD);
   assign cap        = asm_kind ? PCAP : SCAP;

   // A burst starts combinationally in the cycle the engine can take it: straight out of HOLD,
   // or in the same cycle as the result strobe. The engine forgets its string in reset.
   assign start    = pat_staged && ((state == HOLD) || (state == WAIT_RES && sme_valid));
   assign send_str = start && ((state == HOLD) || new_str);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= HOLD;
         rd    <= '0;
      end else begin
         state <= state_nx;
         rd    <= rd_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      rd_nx     = rd;
      sme_rst   = 1'b0;
      isstring  = 1'b0;
      ispattern = 1'b0;
      chardata  = '0;
      free_asm  = 1'b0;
      clr_new   = 1'b0;
      if (send_str) begin
         isstring = 1'b1;
         chardata = str_buf[0];
         if (slen == ONE) begin
            state_nx = EMIT_P;
            rd_nx    = '0;
            clr_new  = 1'b1;
         end else begin
            state_nx = EMIT_S;
            rd_nx    = ONE;
         end
      end else if (start) begin
         ispattern = 1'b1;
         chardata  = asm_buf[0];
         if (asm_len == ONE) begin
            free_asm = 1'b1;
            state_nx = WAIT_RES;
         end else begin
            state_nx = EMIT_P;
            rd_nx    = ONE;
         end
      end else begin
         case (state)
            HOLD: sme_rst = 1'b1;
            EMIT_S: begin
               isstring = 1'b1;
               chardata = str_buf[rd[AW-1:0]];
               if (rd == slen - ONE) begin
                  state_nx = EMIT_P;
                  rd_nx    = '0;
                  clr_new  = 1'b1;
               end else begin
                  rd_nx = rd + ONE;
               end
            end
            EMIT_P: begin
               ispattern = 1'b1;
               chardata  = asm_buf[rd[AW-1:0]];
               if (rd == asm_len - ONE) begin
                  free_asm = 1'b1;
                  state_nx = WAIT_RES;
               end else begin
                  rd_nx = rd + ONE;
               end
            end
            WAIT_RES: if (sme_valid) state_nx = HOLD;
            default: state_nx = HOLD;
         endcase
      end
   end

   // Record assembly. A closed record blocks upstream, so the emit/copy paths and the
   // upstream write path never touch asm in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SMAX; i++) begin
            asm_buf[i] <= '0;
            str_buf[i] <= '0;
         end
         asm_len    <= '0;
         slen       <= '0;
         asm_kind   <= 1'b0;
         asm_open   <= 1'b0;
         asm_closed <= 1'b0;
         new_str    <= 1'b0;
         has_str    <= 1'b0;
         err        <= 1'b0;
      end else begin
         if (free_asm) asm_closed <= 1'b0;
         if (clr_new)  new_str    <= 1'b0;
         if (str_staged && state != EMIT_S) begin
            str_buf    <= asm_buf;
            slen       <= asm_len;
            new_str    <= 1'b1;
            has_str    <= 1'b1;
            asm_closed <= 1'b0;
         end
         if (in_valid && in_ready) begin
            if (in_data == SOS || in_data == SOP) begin
               if (asm_open) err <= 1'b1;
               asm_open <= 1'b1;
               asm_kind <= (in_data == SOP);
               asm_len  <= '0;
            end else if (in_data == EOR) begin
               if (!asm_open) begin
                  err <= 1'b1;
               end else begin
                  asm_open <= 1'b0;
                  if (asm_len != '0) begin
                     if (asm_kind && !has_str) err <= 1'b1;
                     else asm_closed <= 1'b1;
                  end
               end
            end else if (!asm_open) begin
               err <= 1'b1;
            end else if (asm_len < cap) begin
               asm_buf[asm_len[AW-1:0]] <= fold_case(in_data);
               asm_len <= asm_len + ONE;
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sme_feeder.sv
// Scoreboard bench for sme_feeder: a record-level model predicts the engine byte stream,
// a negedge monitor compares bytes, kinds and burst contiguity.
module tb_sme_feeder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       sme_valid = 1'b0;
   logic       in_ready, sme_rst, isstring, ispattern, busy, err;
   logic [7:0] chardata;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_cyc = -10;

   typedef struct packed {
      logic       pat;
      logic       contig;
      logic [7:0] b;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] rec[$];
   logic [7:0] cur_str[$];
   bit has_str, new_str, loaded, waiting, err_exp, staged;

   sme_feeder dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .sme_valid(sme_valid), .sme_rst(sme_rst), .isstring(isstring), .ispattern(ispattern),
      .chardata(chardata), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef SME_FEEDER_CASEFOLD_EN
      if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
      else return b;
`else
      return b;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Monitor: every engine byte must be the next predicted one, in the right cycle.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && (isstring || ispattern)) begin
         chk("one_hot", {31'b0, isstring & ispattern}, 32'd0);
         chk("sme_rst_low", {31'b0, sme_rst}, 32'd0);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: got %0h expected none", chardata);
         end else begin
            e = exp_q.pop_front();
            chk("kind", {31'b0, ispattern}, {31'b0, e.pat});
            chk("chardata", {24'b0, chardata}, {24'b0, e.b});
            if (e.contig) chk("gap", cyc, last_cyc + 1);
         end
         last_cyc = cyc;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      while (!in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic fill(input int n);
      rec.delete();
      for (int i = 0; i < n; i++) rec.push_back(8'($urandom_range(32, 126)));
   endtask

   // Sends rec as one record and updates the record-level model.
   task automatic send_record(input bit is_pat);
      int n;
      bit first;
      n = rec.size();
      send_byte(is_pat ? 8'h02 : 8'h01);
      foreach (rec[i]) send_byte(rec[i]);
      send_byte(8'h04);
      if (!is_pat) begin
         if (n > 32) err_exp = 1;
         if (n > 0) begin
            cur_str.delete();
            for (int i = 0; i < n && i < 32; i++) cur_str.push_back(fold(rec[i]));
            has_str = 1;
            new_str = 1;
         end
      end else begin
         if (n > 8) err_exp = 1;
         if (n > 0) begin
            if (!has_str) begin
               err_exp = 1;
            end else begin
               first = 1;
               if (!loaded || new_str) begin
                  foreach (cur_str[i]) begin
                     exp_q.push_back({1'b0, !first, cur_str[i]});
                     first = 0;
                  end
               end
               for (int i = 0; i < n && i < 8; i++) begin
                  exp_q.push_back({1'b1, !first, fold(rec[i])});
                  first = 0;
               end
               new_str = 0;
               loaded  = 1;
               if (waiting) staged = 1;
            end
         end
      end
   endtask

   task automatic pulse_valid();
      sme_valid = 1'b1;
      @(negedge clk);
      chk("start_same_cycle", {31'b0, isstring | ispattern}, {31'b0, staged});
      @(posedge clk);
      #1;
      sme_valid = 1'b0;
      if (staged) begin
         staged = 0;
      end else begin
         waiting = 0;
         loaded  = 0;
         @(negedge clk);
         chk("hold_rst", {31'b0, sme_rst}, 32'd1);
         chk("hold_busy", {31'b0, busy}, 32'd0);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 32'd0);
      exp_q.delete();
      @(negedge clk);
      chk("wait_busy", {31'b0, busy}, 32'd1);
      chk("wait_quiet", {31'b0, isstring | ispattern}, 32'd0);
      @(posedge clk);
      #1;
      waiting = 1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      sme_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      has_str = 0; new_str = 0; loaded = 0; waiting = 0; err_exp = 0; staged = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int plen;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_sme_rst", {31'b0, sme_rst}, 32'd1);
      chk("rst_isstring", {31'b0, isstring}, 32'd0);
      chk("rst_ispattern", {31'b0, ispattern}, 32'd0);
      chk("rst_chardata", {24'b0, chardata}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      @(posedge clk);
      #1;

      // Pattern with no string: discarded, engine stays in reset.
      rec = '{8'h61};
      send_record(1);
      repeat (4) @(posedge clk);
      #1;
      chk("nostr_err", {31'b0, err}, {31'b0, err_exp});
      chk("nostr_sme_rst", {31'b0, sme_rst}, 32'd1);
      chk("nostr_busy", {31'b0, busy}, 32'd0);
      do_reset();
      chk("reset_clears_err", {31'b0, err}, 32'd0);

      // Data byte outside a record.
      send_byte(8'h7A);
      @(negedge clk);
      chk("stray_data_err", {31'b0, err}, 32'd1);
      @(posedge clk);
      #1;
      do_reset();

      // "ab" then "b": string burst then pattern burst back to back.
      rec = '{8'h61, 8'h62};
      send_record(0);
      rec = '{8'h62};
      send_record(1);
      drain();
      chk("clean_err", {31'b0, err}, 32'd0);

      // Second pattern staged during WAIT_RES: no string resend.
      rec = '{8'h61};
      send_record(1);
      pulse_valid();
      drain();

      // Nothing staged: back to HOLD, then full resend.
      pulse_valid();
      rec = '{8'h78};
      send_record(1);
      drain();

      // Over-long pattern truncates to 8 bytes.
      fill(10);
      send_record(1);
      pulse_valid();
      drain();
      chk("ovf_err", {31'b0, err}, 32'd1);

      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 3) == 0) pulse_valid();
         if ($urandom_range(0, 2) == 0) begin
            fill($urandom_range(0, 34));
            send_record(0);
         end
         plen = ($urandom_range(0, 5) == 0) ? $urandom_range(9, 10) : $urandom_range(1, 8);
         fill(plen);
         send_record(1);
         if (waiting && staged) pulse_valid();
         drain();
         chk("rand_err", {31'b0, err}, {31'b0, err_exp});
      end

      // SOS inside an open record restarts it.
      send_byte(8'h01);
      send_byte(8'h71);
      rec = '{8'h63, 8'h64};
      send_record(0);
      err_exp = 1;
      rec = '{8'h65};
      send_record(1);
      pulse_valid();
      drain();
      chk("abort_err", {31'b0, err}, 32'd1);

      // Reset in the middle of a string burst.
      pulse_valid();
      fill(20);
      send_record(0);
      rec = '{8'h7A, 8'h7A};
      send_record(1);
      @(negedge clk);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_isstring", {31'b0, isstring}, 32'd0);
      chk("midrst_ispattern", {31'b0, ispattern}, 32'd0);
      chk("midrst_sme_rst", {31'b0, sme_rst}, 32'd1);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      has_str = 0; new_str = 0; loaded = 0; waiting = 0; err_exp = 0; staged = 0;
      chk("post_rst_ready", {31'b0, in_ready}, 32'd1);
      rec = '{8'h71};
      send_record(0);
      rec = '{8'h71};
      send_record(1);
      drain();
      chk("post_rst_err", {31'b0, err}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
